// File: rtl/count_ctrl_pkg.sv
// Shared widths, command opcodes and FSM state encoding for count_ctrl.
package count_ctrl_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] HALF_RANGE = 4'd8;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_SEEK = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/count_ctrl.sv
// Command-driven controller for an external up/down counter, with an inline
// shadow copy of the counter used to flag (never repair) divergence.
module count_ctrl
    import count_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_data,
    input  logic             abort,
    input  logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] din,
    output logic             load,
    output logic             up_down,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    input  logic             mismatch_clr
);

    state_t           state, state_nx;
    cmd_op_t          op_q;
    cmd_op_t          op_in;
    logic [CNT_W-1:0] shadow, shadow_nx;
    logic [CNT_W-1:0] data_q;
    logic [CNT_W-1:0] steps;
    logic [CNT_W-1:0] seek_dist;
    logic             dir_q;
    logic             seek_up;
    logic             run_last;

    assign op_in     = cmd_op_t'(cmd_op);
    assign seek_dist = cmd_data - shadow;
    assign seek_up   = (seek_dist <= HALF_RANGE);

    // Counter-facing outputs depend only on state and registers.
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        load      = 1'b1;
        din       = shadow;
        up_down   = 1'b0;
        case (state)
            ST_LOAD: din = data_q;
            ST_RUN: begin
                load    = 1'b0;
                up_down = dir_q;
            end
            default: ;
        endcase
        if (load)
            shadow_nx = din;
        else if (up_down)
            shadow_nx = shadow + CNT_W'(1);
        else
            shadow_nx = shadow - CNT_W'(1);
    end

    // Counted runs stop after `steps` reaches 1 (a start of 0 yields 16 steps);
    // seeks stop on the edge where the shadow lands on the target.
    assign run_last = (op_q == OP_SEEK) ? (shadow_nx == data_q) : (steps == CNT_W'(1));

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (op_in)
                        OP_LOAD: state_nx = ST_LOAD;
                        OP_SEEK: state_nx = (cmd_data == shadow) ? ST_DONE : ST_RUN;
                        default: state_nx = ST_RUN;
                    endcase
                end
            end
            ST_LOAD: state_nx = abort ? ST_IDLE : ST_DONE;
            ST_RUN: begin
                if (abort)
                    state_nx = ST_IDLE;
                else if (run_last)
                    state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            shadow <= '0;
            op_q   <= OP_LOAD;
            data_q <= '0;
            steps  <= '0;
            dir_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            shadow <= shadow_nx;
            if (state == ST_IDLE && cmd_valid) begin
                op_q   <= op_in;
                data_q <= cmd_data;
                steps  <= cmd_data;
                dir_q  <= (op_in == OP_UP) || (op_in == OP_SEEK && seek_up);
            end else if (state == ST_RUN) begin
                steps <= steps - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            mismatch <= 1'b0;
        else if (count != shadow)
            mismatch <= 1'b1;
        else if (mismatch_clr)
            mismatch <= 1'b0;
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboarded bench: each command pushes its expected final count; a monitor
// pops and compares on every done pulse. Includes a model of the external counter.
module tb_count_ctrl;
    import count_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       abort;
    logic [3:0] count;
    logic [3:0] din;
    logic       load;
    logic       up_down;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic       mismatch_clr;

    logic [3:0] cnt;
    logic [3:0] glitch;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    count_ctrl dut (
        .clock        (clk),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .abort        (abort),
        .count        (count),
        .din          (din),
        .load         (load),
        .up_down      (up_down),
        .busy         (busy),
        .done         (done),
        .mismatch     (mismatch),
        .mismatch_clr (mismatch_clr)
    );

    // External counter; glitch lets the bench corrupt the observed count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= 4'd0;
        else if (load)
            cnt <= din;
        else if (up_down)
            cnt <= cnt + 4'd1;
        else
            cnt <= cnt - 4'd1;
    end
    assign count = cnt ^ glitch;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("done_count", int'(count), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input cmd_op_t op, input logic [3:0] data);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("ready_timeout", 0, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        resetn       = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = 2'b00;
        cmd_data     = 4'd0;
        abort        = 1'b0;
        mismatch_clr = 1'b0;
        glitch       = 4'd0;

        // Reset-state outputs
        repeat (2) @(negedge clk);
        check("rst_load", int'(load), 1);
        check("rst_din", int'(din), 0);
        check("rst_up_down", int'(up_down), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_mismatch", int'(mismatch), 0);
        resetn = 1'b1;
        tick();

        // LOAD 9
        exp_q.push_back(4'd9);
        issue(OP_LOAD, 4'd9);
        check("load_busy", int'(busy), 1);
        check("load_ready", int'(cmd_ready), 0);
        check("load_din", int'(din), 9);
        tick();
        check("load_count", int'(count), 9);
        check("load_done", int'(done), 1);
        wait_idle();
        check("load_mismatch", int'(mismatch), 0);
        check("load_done_once", done_cnt, 1);

        // UP 3 from 14 wraps through 0
        exp_q.push_back(4'd14);
        issue(OP_LOAD, 4'd14);
        wait_idle();
        exp_q.push_back(4'd1);
        issue(OP_UP, 4'd3);
        check("up_dir", int'(up_down), 1);
        check("up_load", int'(load), 0);
        tick();
        check("up_step1", int'(count), 15);
        tick();
        check("up_step2", int'(count), 0);
        tick();
        check("up_step3", int'(count), 1);
        check("up_done", int'(done), 1);
        wait_idle();

        // SEEK 13 from 2 takes the shorter downward path
        exp_q.push_back(4'd2);
        issue(OP_LOAD, 4'd2);
        wait_idle();
        exp_q.push_back(4'd13);
        issue(OP_SEEK, 4'd13);
        check("seek_dir_down", int'(up_down), 0);
        repeat (5) tick();
        check("seek_count", int'(count), 13);
        check("seek_done", int'(done), 1);
        wait_idle();

        // SEEK to current value: immediate done
        exp_q.push_back(4'd5);
        issue(OP_LOAD, 4'd5);
        wait_idle();
        exp_q.push_back(4'd5);
        issue(OP_SEEK, 4'd5);
        check("seek0_done", int'(done), 1);
        check("seek0_count", int'(count), 5);
        wait_idle();
        check("seek0_total_done", done_cnt, 7);

        // DOWN 16 aborted on the 4th step
        issue(OP_DOWN, 4'd0);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_count", int'(count), 1);
        repeat (3) tick();
        check("abort_held", int'(count), 1);
        check("abort_no_done", done_cnt, 7);

        // Sticky mismatch with clear priority
        glitch = 4'd3;
        tick();
        glitch = 4'd0;
        check("mm_set", int'(mismatch), 1);
        tick();
        check("mm_sticky", int'(mismatch), 1);
        mismatch_clr = 1'b1;
        tick();
        mismatch_clr = 1'b0;
        check("mm_clear", int'(mismatch), 0);
        glitch       = 4'd3;
        mismatch_clr = 1'b1;
        tick();
        glitch       = 4'd0;
        mismatch_clr = 1'b0;
        check("mm_set_wins", int'(mismatch), 1);
        mismatch_clr = 1'b1;
        tick();
        mismatch_clr = 1'b0;

        // Reset mid-command abandons it silently
        issue(OP_UP, 4'd10);
        repeat (2) tick();
        resetn = 1'b0;
        #1;
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_din", int'(din), 0);
        check("rstmid_count", int'(count), 0);
        check("rstmid_ready", int'(cmd_ready), 1);
        check("rstmid_mismatch", int'(mismatch), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) tick();
        check("rstmid_no_done", done_cnt, 7);
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
